// File: rtl/counter_ctrl_defs_pkg.sv
// Shared definitions for the counter control stage: FSM state codes and
// the CONTROL direction levels.
package counter_ctrl_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_TURN = 2'b10
    } state_e;

    localparam logic CONTROL_UP   = 1'b1;
    localparam logic CONTROL_DOWN = 1'b0;

endpackage

// File: rtl/counter_ctrl_input_button_filter.sv
// One push-button front end: 2-flop synchroniser, debounce filter and a
// one-cycle pulse on each accepted press (filtered 0->1 transition).
module button_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);

    logic           sync1_q;
    logic           sync2_q;
    logic           level_q;
    logic           level_d;
    logic           level_dly_q;
    logic [DBW-1:0] cnt_q;
    logic [DBW-1:0] cnt_d;

    // The counter reaching DEBOUNCE_CYCLES is folded into the same edge as
    // the level update, so the counter itself never holds that value.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b1;
            level_dly_q <= 1'b1;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
        end
    end

    assign press = level_q & ~level_dly_q;

endmodule

// File: rtl/counter_ctrl_input.sv
// Run/stop, direction and clear sequencing for the up/down counter, with a
// paused turnaround whenever direction changes while running.
module counter_ctrl_input
    import counter_ctrl_defs::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TURN_CYCLES     = 2
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       BTN_RUN,
    input  logic       BTN_DIR,
    input  logic       BTN_CLR,
    output logic       ENABLE,
    output logic       CONTROL,
    output logic       CLR_REQ,
    output logic [1:0] STATE
);

    localparam int unsigned TCW = $clog2(TURN_CYCLES + 1);

    logic           run_press;
    logic           dir_press;
    logic           clr_press;

    state_e         state_q;
    state_e         state_d;
    logic           enable_q;
    logic           enable_d;
    logic           control_q;
    logic           control_d;
    logic           clr_req_q;
    logic           clr_req_d;
    logic [TCW-1:0] turn_cnt_q;
    logic [TCW-1:0] turn_cnt_d;

    button_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
        .clk     (CLOCK),
        .rst     (RESET),
        .btn_raw (BTN_RUN),
        .press   (run_press)
    );

    button_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir (
        .clk     (CLOCK),
        .rst     (RESET),
        .btn_raw (BTN_DIR),
        .press   (dir_press)
    );

    button_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk     (CLOCK),
        .rst     (RESET),
        .btn_raw (BTN_CLR),
        .press   (clr_press)
    );

    always_comb begin
        state_d    = state_q;
        enable_d   = enable_q;
        control_d  = control_q;
        clr_req_d  = 1'b0;
        turn_cnt_d = '0;
        if (clr_press) begin
            clr_req_d = 1'b1;
            state_d   = ST_IDLE;
            enable_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    enable_d = 1'b0;
                    if (dir_press) control_d = ~control_q;
                    if (run_press) begin
                        state_d  = ST_RUN;
                        enable_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    enable_d = 1'b1;
                    if (run_press) begin
                        state_d  = ST_IDLE;
                        enable_d = 1'b0;
                        if (dir_press) control_d = ~control_q;
                    end else if (dir_press) begin
                        state_d  = ST_TURN;
                        enable_d = 1'b0;
                    end
                end
                ST_TURN: begin
                    // Toggle lands on the first edge in TURN even if a run
                    // press aborts the turnaround on that same edge.
                    enable_d   = 1'b0;
                    turn_cnt_d = turn_cnt_q + 1'b1;
                    if (turn_cnt_q == '0) control_d = ~control_q;
                    if (run_press) begin
                        state_d    = ST_IDLE;
                        turn_cnt_d = '0;
                    end else if (turn_cnt_q == TCW'(TURN_CYCLES - 1)) begin
                        state_d    = ST_RUN;
                        enable_d   = 1'b1;
                        turn_cnt_d = '0;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    enable_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            enable_q   <= 1'b0;
            control_q  <= CONTROL_UP;
            clr_req_q  <= 1'b0;
            turn_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            control_q  <= control_d;
            clr_req_q  <= clr_req_d;
            turn_cnt_q <= turn_cnt_d;
        end
    end

    assign ENABLE  = enable_q;
    assign CONTROL = control_q;
    assign CLR_REQ = clr_req_q;
    assign STATE   = state_q;

endmodule

// File: tb/tb_counter_ctrl_input.sv
// Directed bench for counter_ctrl_input with DEBOUNCE_CYCLES=4, TURN_CYCLES=2:
// a vector table for single-button sequences plus hand-timed corner cases.
module tb_counter_ctrl_input;

    logic       clk;
    logic       rst;
    logic       btn_run;
    logic       btn_dir;
    logic       btn_clr;
    logic       enable;
    logic       control;
    logic       clr_req;
    logic [1:0] state;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    counter_ctrl_input #(
        .DEBOUNCE_CYCLES (4),
        .TURN_CYCLES     (2)
    ) dut (
        .CLOCK   (clk),
        .RESET   (rst),
        .BTN_RUN (btn_run),
        .BTN_DIR (btn_dir),
        .BTN_CLR (btn_clr),
        .ENABLE  (enable),
        .CONTROL (control),
        .CLR_REQ (clr_req),
        .STATE   (state)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    initial begin
        #(200 * 20000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        run;
        logic        dir;
        logic        clr;
        int unsigned cycles;
        logic        en;
        logic        ctl;
        logic        creq;
        logic [1:0]  st;
    } vec_t;

    vec_t  vecs[$];
    string names[$];

    task automatic add(input string nm, input logic r, input logic ru, input logic di,
                       input logic cl, input int unsigned n, input logic en,
                       input logic ctl, input logic creq, input logic [1:0] st);
        vec_t v;
        v.rst = r; v.run = ru; v.dir = di; v.clr = cl; v.cycles = n;
        v.en = en; v.ctl = ctl; v.creq = creq; v.st = st;
        vecs.push_back(v);
        names.push_back(nm);
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic en, input logic ctl,
                         input logic creq, input logic [1:0] st);
        checks++;
        if (enable !== en || control !== ctl || clr_req !== creq || state !== st) begin
            failures++;
            $display("FAIL %s: got en=%b ctl=%b clr=%b st=%b, want en=%b ctl=%b clr=%b st=%b",
                     nm, enable, control, clr_req, state, en, ctl, creq, st);
        end
    endtask

    task automatic drive(input logic r, input logic ru, input logic di, input logic cl);
        rst = r; btn_run = ru; btn_dir = di; btn_clr = cl;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0);

        //   name               rst run dir clr  n  en ctl clr st
        add("reset",             1, 0, 0, 0,  2, 0, 1, 0, 2'b00);
        add("idle_after_reset",  0, 0, 0, 0,  8, 0, 1, 0, 2'b00);
        add("run_lat_minus1",    0, 1, 0, 0,  6, 0, 1, 0, 2'b00);
        add("run_lat_7",         0, 1, 0, 0,  1, 1, 1, 0, 2'b01);
        add("run_hold",          0, 1, 0, 0,  3, 1, 1, 0, 2'b01);
        add("run_release",       0, 0, 0, 0,  8, 1, 1, 0, 2'b01);
        add("glitch3_high",      0, 1, 0, 0,  3, 1, 1, 0, 2'b01);
        add("glitch3_reject",    0, 0, 0, 0,  8, 1, 1, 0, 2'b01);
        add("stop6_pre",         0, 1, 0, 0,  6, 1, 1, 0, 2'b01);
        add("stop6_edge7",       0, 0, 0, 0,  1, 0, 1, 0, 2'b00);
        add("stop6_settle",      0, 0, 0, 0,  8, 0, 1, 0, 2'b00);
        add("pulse4_high",       0, 1, 0, 0,  4, 0, 1, 0, 2'b00);
        add("pulse4_pre",        0, 0, 0, 0,  2, 0, 1, 0, 2'b00);
        add("pulse4_accept",     0, 0, 0, 0,  1, 1, 1, 0, 2'b01);
        add("pulse4_settle",     0, 0, 0, 0,  8, 1, 1, 0, 2'b01);
        add("stop2_pre",         0, 1, 0, 0,  6, 1, 1, 0, 2'b01);
        add("stop2_edge",        0, 0, 0, 0,  1, 0, 1, 0, 2'b00);
        add("stop2_settle",      0, 0, 0, 0,  8, 0, 1, 0, 2'b00);
        add("rundir_idle_pre",   0, 1, 1, 0,  6, 0, 1, 0, 2'b00);
        add("rundir_idle_edge",  0, 0, 0, 0,  1, 1, 0, 0, 2'b01);
        add("rundir_idle_set",   0, 0, 0, 0,  8, 1, 0, 0, 2'b01);
        add("stop3_pre",         0, 1, 0, 0,  6, 1, 0, 0, 2'b01);
        add("stop3_edge",        0, 0, 0, 0,  1, 0, 0, 0, 2'b00);
        add("stop3_settle",      0, 0, 0, 0,  8, 0, 0, 0, 2'b00);
        add("dir_idle_pre",      0, 0, 1, 0,  6, 0, 0, 0, 2'b00);
        add("dir_idle_edge",     0, 0, 0, 0,  1, 0, 1, 0, 2'b00);
        add("dir_idle_settle",   0, 0, 0, 0,  8, 0, 1, 0, 2'b00);
        add("run4_pre",          0, 1, 0, 0,  6, 0, 1, 0, 2'b00);
        add("run4_edge",         0, 0, 0, 0,  1, 1, 1, 0, 2'b01);
        add("run4_settle",       0, 0, 0, 0,  8, 1, 1, 0, 2'b01);
        add("rundir_run_pre",    0, 1, 1, 0,  6, 1, 1, 0, 2'b01);
        add("rundir_run_edge",   0, 0, 0, 0,  1, 0, 0, 0, 2'b00);
        add("rundir_run_settle", 0, 0, 0, 0,  8, 0, 0, 0, 2'b00);
        add("dir2_pre",          0, 0, 1, 0,  6, 0, 0, 0, 2'b00);
        add("dir2_edge",         0, 0, 0, 0,  1, 0, 1, 0, 2'b00);
        add("dir2_settle",       0, 0, 0, 0,  8, 0, 1, 0, 2'b00);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].run, vecs[i].dir, vecs[i].clr);
            step(vecs[i].cycles);
            check(names[i], vecs[i].en, vecs[i].ctl, vecs[i].creq, vecs[i].st);
        end

        // Turnaround while running up: pause, toggle, resume on fixed edges.
        drive(0, 1, 0, 0); step(7); check("turn_setup_run", 1, 1, 0, 2'b01);
        drive(0, 0, 0, 0); step(8);
        drive(0, 0, 1, 0); step(7); check("turn_enter_N",   0, 1, 0, 2'b10);
        step(1);                    check("turn_toggle_N1", 0, 0, 0, 2'b10);
        step(1);                    check("turn_exit_N2",   1, 0, 0, 2'b01);
        drive(0, 0, 0, 0); step(8); check("turn_settle",    1, 0, 0, 2'b01);

        // Clear together with direction while running.
        drive(0, 0, 1, 1); step(6); check("clr_pre",        1, 0, 0, 2'b01);
        step(1);                    check("clr_edge",       0, 0, 1, 2'b00);
        step(1);                    check("clr_one_cycle",  0, 0, 0, 2'b00);
        drive(0, 0, 0, 0); step(8); check("clr_no_dir",     0, 0, 0, 2'b00);

        // Run press landing on the toggle edge of a turnaround.
        drive(0, 1, 0, 0); step(7); check("rt_setup_run",   1, 0, 0, 2'b01);
        drive(0, 0, 0, 0); step(8);
        drive(0, 0, 1, 0); step(1);
        drive(0, 1, 1, 0); step(6); check("rt_turn_enter",  0, 0, 0, 2'b10);
        step(1);                    check("run_in_turn",    0, 1, 0, 2'b00);
        step(1);                    check("run_in_turn_hold", 0, 1, 0, 2'b00);
        drive(0, 0, 0, 0); step(8);

        // Clear landing before the toggle edge aborts the turnaround.
        drive(0, 1, 0, 0); step(7); check("ct_setup_run",   1, 1, 0, 2'b01);
        drive(0, 0, 0, 0); step(8);
        drive(0, 0, 1, 0); step(1);
        drive(0, 0, 1, 1); step(6); check("ct_turn_enter",  0, 1, 0, 2'b10);
        step(1);                    check("clr_in_turn",    0, 1, 1, 2'b00);
        step(1);                    check("clr_no_toggle",  0, 1, 0, 2'b00);
        drive(0, 0, 0, 0); step(8);

        // Button held through reset yields no press until released and re-pressed.
        drive(0, 0, 1, 0); step(7); check("pre_rst_down",   0, 0, 0, 2'b00);
        drive(0, 0, 0, 0); step(8);
        drive(1, 1, 0, 0); step(2); check("reset_held",     0, 1, 0, 2'b00);
        drive(0, 1, 0, 0); step(10); check("no_press_after_reset", 0, 1, 0, 2'b00);
        drive(0, 0, 0, 0); step(6);
        drive(0, 1, 0, 0); step(6); check("repress_pre",    0, 1, 0, 2'b00);
        step(1);                    check("repress_edge",   1, 1, 0, 2'b01);
        drive(0, 0, 0, 0); step(8);

        // Reset in the middle of a turnaround after the toggle.
        drive(0, 0, 1, 0); step(7); check("mr_turn_enter",  0, 1, 0, 2'b10);
        step(1);                    check("mr_toggle",      0, 0, 0, 2'b10);
        drive(1, 0, 1, 0); step(1); check("reset_mid_turn", 0, 1, 0, 2'b00);
        drive(0, 0, 0, 0); step(8); check("after_mid_reset", 0, 1, 0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
